// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-mode SPI master: FSM state codes,
// latched transfer mode and a bit-reversal helper for LSB-first framing.
package spi_pkg;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t IDLE     = 3'd0;
    localparam spi_state_t SETUP    = 3'd1;
    localparam spi_state_t TRANSFER = 3'd2;
    localparam spi_state_t HOLD     = 3'd3;
    localparam spi_state_t DONE     = 3'd4;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

    // Reverses the low n bits of v; bits at and above n come back as zero.
    function automatic logic [63:0] bit_rev(input logic [63:0] v, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < n) r[6'(i)] = v[6'(n - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_master_multi_sck_gen.sv
// SCK generator: H-cycle half-period timer, registered SCK toggle and
// leading/trailing edge strobes that coincide with the clk edge where SCK changes.
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int DIV_WIDTH   = 8,
    parameter int EW          = $clog2(2 * DATA_LENGTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_enable,
    input  logic [DIV_WIDTH-1:0] i_h,
    input  logic                 i_cpol,
    output logic                 o_spi_sck,
    output logic                 o_lead_edge,
    output logic                 o_trail_edge,
    output logic                 o_tick,
    output logic [EW-1:0]        o_edge_count
);

    logic [DIV_WIDTH-1:0] r_hc;
    logic [EW-1:0]        r_ecnt;
    logic                 r_sck;
    logic                 w_tick;
    logic                 w_edge;

    assign w_tick = i_enable && (r_hc == i_h - DIV_WIDTH'(1));
    // Ticks after the last edge (the HOLD interval) must not toggle SCK.
    assign w_edge = w_tick && (r_ecnt < EW'(2 * DATA_LENGTH));

    assign o_lead_edge  = w_edge && !r_ecnt[0];
    assign o_trail_edge = w_edge &&  r_ecnt[0];
    assign o_tick       = w_tick;
    assign o_edge_count = r_ecnt;
    assign o_spi_sck    = r_sck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hc   <= '0;
            r_ecnt <= '0;
            r_sck  <= 1'b0;
        end else if (!i_enable) begin
            r_hc   <= '0;
            r_ecnt <= '0;
            r_sck  <= i_cpol;
        end else begin
            r_hc <= w_tick ? '0 : r_hc + DIV_WIDTH'(1);
            if (w_edge) begin
                r_ecnt <= r_ecnt + EW'(1);
                r_sck  <= ~r_sck;
            end
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// Multi-mode SPI master: FSM, TX/RX shift registers and one-hot chip-select
// decode around the SCK generator. One DATA_LENGTH-bit transfer per start.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter  int DATA_LENGTH = 8,
    parameter  int NUM_CS      = 4,
    parameter  int DIV_WIDTH   = 8,
    localparam int CSW         = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DATA_LENGTH-1:0] data_in,
    input  logic                   cpol,
    input  logic                   cpha,
    input  logic                   lsb_first,
    input  logic [CSW-1:0]         cs_sel,
    input  logic [DIV_WIDTH-1:0]   clk_div,
    output logic [DATA_LENGTH-1:0] data_out,
    output logic                   busy,
    output logic                   done,
    output logic                   spi_sck,
    output logic                   spi_mosi,
    input  logic                   spi_miso,
    output logic [NUM_CS-1:0]      spi_cs_n
);

    localparam int EW = $clog2(2 * DATA_LENGTH) + 1;

    spi_state_t             r_state;
    spi_mode_t              r_mode;
    logic [CSW-1:0]         r_cs;
    logic [DIV_WIDTH-1:0]   r_h;
    logic [DATA_LENGTH-1:0] r_tx;
    logic [DATA_LENGTH-1:0] r_rx;
    logic [DATA_LENGTH-1:0] r_data_out;
    logic                   r_mosi;

    logic                   w_active;
    logic                   w_cpol;
    logic                   w_lead;
    logic                   w_trail;
    logic                   w_tick;
    logic [EW-1:0]          w_ecnt;
    logic                   w_last_next;
    logic                   w_drive;
    logic                   w_sample;
    logic [DATA_LENGTH-1:0] w_tx_init;
    logic [DATA_LENGTH-1:0] w_rx_final;

    assign w_active = (r_state == SETUP) || (r_state == TRANSFER) || (r_state == HOLD);
    // SCK tracks the live cpol input while idle so the first SETUP cycle already
    // shows the level being latched with start.
    assign w_cpol   = (r_state == IDLE) ? cpol : r_mode.cpol;

    spi_sck_gen #(
        .DATA_LENGTH (DATA_LENGTH),
        .DIV_WIDTH   (DIV_WIDTH),
        .EW          (EW)
    ) u_sck_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (w_active),
        .i_h          (r_h),
        .i_cpol       (w_cpol),
        .o_spi_sck    (spi_sck),
        .o_lead_edge  (w_lead),
        .o_trail_edge (w_trail),
        .o_tick       (w_tick),
        .o_edge_count (w_ecnt)
    );

    // Both shift registers always work MSB-first; LSB-first is a reversal at the ends.
    assign w_tx_init  = lsb_first ? DATA_LENGTH'(bit_rev(64'(data_in), DATA_LENGTH)) : data_in;
    assign w_rx_final = r_mode.lsb_first ? DATA_LENGTH'(bit_rev(64'(r_rx), DATA_LENGTH)) : r_rx;

    assign w_last_next = (w_ecnt == EW'(2 * DATA_LENGTH - 1));
    assign w_drive     = r_mode.cpha ? w_lead  : (w_trail && !w_last_next);
    assign w_sample    = r_mode.cpha ? w_trail : w_lead;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mode     <= '0;
            r_cs       <= '0;
            r_h        <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_data_out <= '0;
            r_mosi     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= SETUP;
                    r_mode  <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
                    r_cs    <= cs_sel;
                    r_h     <= (clk_div == '0) ? DIV_WIDTH'(1) : clk_div;
                    r_rx    <= '0;
                    if (!cpha) begin
                        r_mosi <= w_tx_init[DATA_LENGTH-1];
                        r_tx   <= {w_tx_init[DATA_LENGTH-2:0], 1'b0};
                    end else begin
                        r_tx   <= w_tx_init;
                    end
                end
                SETUP:    if (w_tick) r_state <= TRANSFER;
                TRANSFER: if (w_tick && w_last_next) r_state <= HOLD;
                HOLD: if (w_tick) begin
                    r_state    <= DONE;
                    r_mosi     <= 1'b0;
                    r_data_out <= w_rx_final;
                end
                DONE:     r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
            if (w_drive) begin
                r_mosi <= r_tx[DATA_LENGTH-1];
                r_tx   <= {r_tx[DATA_LENGTH-2:0], 1'b0};
            end
            if (w_sample) r_rx <= {r_rx[DATA_LENGTH-2:0], spi_miso};
        end
    end

    for (genvar g = 0; g < NUM_CS; g++) begin : g_cs
        assign spi_cs_n[g] = ~(w_active && (r_cs == CSW'(g)));
    end

    assign busy     = w_active;
    assign done     = (r_state == DONE);
    assign data_out = r_data_out;
    assign spi_mosi = r_mosi;

endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
- Parametrised SPI master, the next generation of the team's single-mode SPI master.
- Adds:
  - all four SPI modes (CPOL/CPHA)
  - runtime clock divider
  - MSB/LSB-first selection
  - NUM_CS one-hot-decoded chip selects
  - CS setup/hold guard intervals
- Sits between the CPU-side register block and the SPI pads; one transfer of DATA_LENGTH bits per start.

Parameters:
- DATA_LENGTH, 8, bits per transfer (>=2)
- NUM_CS, 4, number of chip-select outputs (>=1)
- DIV_WIDTH, 8, width of the runtime clock-divider input

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  transfer request, sampled only in IDLE
- data_in  in  DATA_LENGTH  word to transmit
- cpol  in  1  SCK idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- lsb_first  in  1  1: LSB shifted first
- cs_sel  in  $clog2(NUM_CS) (min 1)  target slave index
- clk_div  in  DIV_WIDTH  SCK half-period H in clk cycles; 0 treated as 1
- data_out  out  DATA_LENGTH  received word
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- spi_sck  out  1  serial clock
- spi_mosi  out  1  master-out data
- spi_miso  in  1  master-in data
- spi_cs_n  out  NUM_CS  active-low chip selects

Behaviour:
- Reset values: busy=0, done=0, data_out=0, spi_mosi=0, spi_cs_n=all 1s, spi_sck=0, state=IDLE. An asynchronous reset during a transfer aborts it immediately; there is no done pulse.
- Start handshake: start is accepted in IDLE at cycle t. At that point cpol, cpha, lsb_first, cs_sel, H and data_in are latched. Input changes after t have no effect on the transfer.
- Start while busy or in DONE is ignored (not queued).
- cs_sel >= NUM_CS: the transfer runs fully but no cs_n asserts.
- In IDLE, spi_sck follows the cpol input. During a transfer it follows the latched cpol.
- States: IDLE -> SETUP -> TRANSFER -> HOLD -> DONE -> IDLE.
- SETUP (cycles t+1..t+H):
  - spi_cs_n[cs_sel]=0, busy=1, spi_sck=cpol.
  - If cpha=0, spi_mosi = first bit from t+1.
- TRANSFER:
  - SCK edge k (k=1..2*DATA_LENGTH) is the registered spi_sck toggle at cycle t+1+k*H.
  - The last edge returns spi_sck to cpol.
- Data edges, cpha=0:
  - Odd edges sample spi_miso (value at the clk edge where spi_sck changes).
  - Even edges except the last drive the next bit on spi_mosi.
- Data edges, cpha=1:
  - Odd edges drive the bit; the first bit appears at edge 1.
  - Even edges sample.
- Bit order:
  - lsb_first=0: tx shifts out MSB first; rx is assembled MSB first.
  - lsb_first=1: both directions are bit-reversed (LSB first).
- HOLD (H cycles after the last edge): cs_n stays low, spi_sck=cpol, mosi holds its last bit.
- DONE (single cycle at t+1+(2*DATA_LENGTH+1)*H):
  - done=1, busy=0, all cs_n=1, spi_mosi=0.
  - data_out is loaded the same cycle and holds until the next DONE.
- Back-to-back: IDLE is re-entered the cycle after DONE. Start may be asserted there; minimum gap between transfers is 2 cycles.
- Counters: the half-period counter runs 0..H-1. The edge counter is $clog2(2*DATA_LENGTH)+1 bits wide. There is no wrap-around inside a transfer; both counters clear on IDLE.
- clk_div=1: SCK = clk/2, fully functional.

Decomposition:
- Shared package spi_pkg holds:
  - typedef spi_state_t {IDLE, SETUP, TRANSFER, HOLD, DONE}
  - typedef spi_mode_t (cpol, cpha, lsb_first)
  - function for bit-reversal
- Sub-module spi_sck_gen:
  - inputs: enable, H, cpol
  - outputs: spi_sck, lead_edge and trail_edge one-cycle strobes, edge_count
- The top module holds the FSM, shift registers and CS decode.

Test Plan:
- Mode 0, H=2, L=8, cs_sel=1, data_in=0xA5, slave returns 0x3C:
  - MOSI bits 1,0,1,0,0,1,0,1 stable at rising edges
  - cs_n=4'b1101 during transfer
  - done at t+35, data_out=0x3C
- Mode 3 (cpol=1, cpha=1), H=1, data_in=0x81, slave returns 0x7E:
  - sck idles 1; sampling on rising (trailing) edges
  - done at t+18, data_out=0x7E
- lsb_first=1, mode 1, data_in=0x01, slave 0x80:
  - MOSI first bit=1, then seven 0s
  - data_out=0x80 (received LSB-first)
- Start pulsed mid-transfer with different data and cs_sel:
  - ignored; latched config is unchanged
  - exactly one done pulse
  - back-to-back start at IDLE after DONE begins a new SETUP next cycle
- rst_n dropped during TRANSFER at edge 5:
  - all outputs at reset values asynchronously, no done
  - a new transfer after release completes correctly
- clk_div=0 behaves as H=1; clk_div=255 gives a 510-cycle SCK period with correct data.
